// File: rtl/hash_feed_pkg.sv
// Shared definitions for the hash message feeder and the digest-side collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the feeder FSM state encoding and the default sizing so both ends of the
// hash datapath agree on message geometry without duplicating constants.
package hash_feed_pkg;

    // Largest message, in bytes, that a single request may carry.
    localparam int HF_MAX_BYTES = 128;

    // Width of the message length field; must hold 0..HF_MAX_BYTES inclusive.
    localparam int HF_LEN_W = 8;

    // Feeder sequencing:
    //   IDLE     - waiting for a request, req_ready high
    //   START    - one-cycle start pulse to open the hash
    //   WAIT_RDY - hold until the hash core can take bytes
    //   SEND     - stream bytes, most significant captured byte first
    //   FINISH   - one-cycle finish pulse to close the hash
    //   WAIT_END - wait for the falling edge of the core's dout_end strobe
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_WAIT_RDY = 3'd2,
        ST_SEND     = 3'd3,
        ST_FINISH   = 3'd4,
        ST_WAIT_END = 3'd5
    } feed_state_e;

endpackage

// File: rtl/hash_msg_feeder.sv
// Feeds a captured message byte-by-byte into a hash core, framed by start/finish pulses.
// Latency: 2 cycles from request accept to first din_valid when din_ready is held high.
// Backpressure: din_ready low stalls the byte stream with din/din_end held; req_ready only in IDLE.
//
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake; msg and msg_len are captured on accept
//   msg, msg_len         - message (byte k at msg[8k+:8]) and its length in bytes
//   start, finish        - one-cycle pulses opening and closing the hash
//   din/din_valid/din_ready/din_end - byte stream to the hash core, byte len-1 first
//   dout_end             - end-of-digest strobe from the core; its falling edge completes a hash
//   busy, done, len_err  - status: not idle, completion pulse, sticky length saturation flag
//
// All outputs except req_ready come straight from flops. req_ready is a decode of the
// state register only, so it never depends combinationally on an input either.
module hash_msg_feeder
    import hash_feed_pkg::*;
#(
    parameter int MAX_BYTES = HF_MAX_BYTES,
    // Must be at least $clog2(MAX_BYTES+1) so MAX_BYTES itself is representable.
    parameter int LEN_W     = HF_LEN_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [8*MAX_BYTES-1:0] msg,
    input  logic [LEN_W-1:0]       msg_len,
    output logic                   start,
    output logic                   finish,
    output logic [7:0]             din,
    output logic                   din_valid,
    input  logic                   din_ready,
    output logic                   din_end,
    input  logic                   dout_end,
    output logic                   busy,
    output logic                   done,
    output logic                   len_err
);

    // Byte index width and the matching bit-offset width for the part-select.
    // Eight bits per byte means the bit offset is the byte index with three zero LSBs.
    localparam int IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int BIT_W = IDX_W + 3;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
    localparam logic [LEN_W-1:0] TWO     = LEN_W'(2);

    feed_state_e            state_q,     state_d;
    logic [8*MAX_BYTES-1:0] msg_q,       msg_d;
    logic [LEN_W-1:0]       cnt_q,       cnt_d;
    logic [7:0]             din_q,       din_d;
    logic                   din_valid_q, din_valid_d;
    logic                   din_end_q,   din_end_d;
    logic                   start_q,     start_d;
    logic                   finish_q,    finish_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;
    logic                   len_err_q,   len_err_d;
    logic                   dout_end_q,  dout_end_d;

    // Byte to present next and its bit offset inside msg_q.
    logic [IDX_W-1:0]       byte_idx;
    logic [BIT_W-1:0]       bit_off;

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        cnt_d       = cnt_q;
        din_d       = din_q;
        din_valid_d = din_valid_q;
        din_end_d   = din_end_q;
        start_d     = 1'b0;
        finish_d    = 1'b0;
        done_d      = 1'b0;
        len_err_d   = len_err_q;
        dout_end_d  = dout_end;
        byte_idx    = '0;
        bit_off     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    msg_d = msg;
                    // Oversized requests are clamped rather than rejected; len_err
                    // records that the tail of the request was dropped.
                    if (msg_len > MAX_LEN) begin
                        cnt_d     = MAX_LEN;
                        len_err_d = 1'b1;
                    end else begin
                        cnt_d     = msg_len;
                        len_err_d = 1'b0;
                    end
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                state_d = ST_WAIT_RDY;
            end

            ST_WAIT_RDY: begin
                if (din_ready) begin
                    if (cnt_q != '0) begin
                        // Preload the first byte (index cnt-1) so din is stable
                        // from the first cycle din_valid is high.
                        byte_idx    = IDX_W'(cnt_q - ONE);
                        bit_off     = {byte_idx, 3'b000};
                        din_d       = msg_q[bit_off +: 8];
                        din_valid_d = 1'b1;
                        din_end_d   = (cnt_q == ONE);
                        state_d     = ST_SEND;
                    end else begin
                        finish_d = 1'b1;
                        state_d  = ST_FINISH;
                    end
                end
            end

            ST_SEND: begin
                // Nothing moves unless the current byte is actually taken, which
                // keeps din/din_end frozen across any stall.
                if (din_ready) begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        din_valid_d = 1'b0;
                        din_end_d   = 1'b0;
                        din_d       = 8'h00;
                        finish_d    = 1'b1;
                        state_d     = ST_FINISH;
                    end else begin
                        // Next byte sits at index (cnt-1)-1 = cnt-2.
                        byte_idx  = IDX_W'(cnt_q - TWO);
                        bit_off   = {byte_idx, 3'b000};
                        din_d     = msg_q[bit_off +: 8];
                        din_end_d = (cnt_q == TWO);
                    end
                end
            end

            ST_FINISH: begin
                state_d = ST_WAIT_END;
            end

            ST_WAIT_END: begin
                // Only the falling edge of dout_end completes a hash, and only here;
                // edges seen in other states are discarded by construction.
                if (dout_end_q && !dout_end) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // Control and output flops. Reset aborts any message in flight and leaves
    // every strobe low, so an interrupted hash never sees finish or done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            din_q       <= 8'h00;
            din_valid_q <= 1'b0;
            din_end_q   <= 1'b0;
            start_q     <= 1'b0;
            finish_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            dout_end_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            din_q       <= din_d;
            din_valid_q <= din_valid_d;
            din_end_q   <= din_end_d;
            start_q     <= start_d;
            finish_q    <= finish_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            len_err_q   <= len_err_d;
            dout_end_q  <= dout_end_d;
        end
    end

    // The message store is only read while cnt_q is nonzero, which reset clears,
    // so its contents need no reset.
    always_ff @(posedge clk) begin
        msg_q <= msg_d;
    end

    assign req_ready = (state_q == ST_IDLE);
    assign start     = start_q;
    assign finish    = finish_q;
    assign din       = din_q;
    assign din_valid = din_valid_q;
    assign din_end   = din_end_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_hash_msg_feeder.sv
module tb_hash_msg_feeder;
    import hash_feed_pkg::*;

    localparam int MB = 128;
    localparam int LW = 8;
    localparam int MW = 8 * MB;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [MW-1:0] msg;
    logic [LW-1:0] msg_len;
    logic          start;
    logic          finish;
    logic [7:0]    din;
    logic          din_valid;
    logic          din_ready;
    logic          din_end;
    logic          dout_end;
    logic          busy;
    logic          done;
    logic          len_err;

    hash_msg_feeder #(.MAX_BYTES(MB), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .msg       (msg),
        .msg_len   (msg_len),
        .start     (start),
        .finish    (finish),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din_end   (din_end),
        .dout_end  (dout_end),
        .busy      (busy),
        .done      (done),
        .len_err   (len_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected bytes in send order, pushed when a request is driven.
    typedef struct packed {
        logic [7:0] b;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   hold_q[$];
    int   xfer_cnt, valid_cycles, start_cnt, finish_cnt, done_cnt, hold_cnt;
    logic stall_prev;
    logic [7:0] prev_din;
    logic prev_end;
    exp_t mon_e;

    // Monitor at the falling edge: inputs change just after posedge, so what is seen
    // here is exactly what the next posedge will sample.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
            hold_cnt   = 0;
        end else begin
            if (start || finish) check("start_finish_exclusive", {31'd0, start && finish}, 32'd0);
            if (start)  start_cnt++;
            if (finish) finish_cnt++;
            if (done)   done_cnt++;
            if (stall_prev) begin
                check("stall_valid_held", {31'd0, din_valid}, 32'd1);
                check("stall_din_held", {24'd0, din}, {24'd0, prev_din});
                check("stall_end_held", {31'd0, din_end}, {31'd0, prev_end});
            end
            if (din_valid) begin
                valid_cycles++;
                hold_cnt++;
                if (din_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got din 0x%0h, expected no byte", din);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("din_byte", {24'd0, din}, {24'd0, mon_e.b});
                        check("din_end", {31'd0, din_end}, {31'd0, mon_e.last});
                    end
                    xfer_cnt++;
                    hold_q.push_back(hold_cnt);
                    hold_cnt   = 0;
                    stall_prev = 1'b0;
                end else begin
                    stall_prev = 1'b1;
                    prev_din   = din;
                    prev_end   = din_end;
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    typedef struct {
        logic [MW-1:0] msg;
        logic [LW-1:0] len;
        int            stall_after;   // transfers completed before din_ready drops
        int            stall_cycles;  // cycles din_ready is held low
        logic          exp_len_err;
        int            exp_bytes;
        logic [7:0]    exp_first;
    } vec_t;

    task automatic clear_sb();
        exp_q.delete();
        hold_q.delete();
        xfer_cnt = 0; valid_cycles = 0; start_cnt = 0;
        finish_cnt = 0; done_cnt = 0; hold_cnt = 0;
    endtask

    task automatic wait_req_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int t;
        int stall_done;
        int tf_exp;
        wait_req_ready(tag);
        clear_sb();
        for (int k = v.exp_bytes - 1; k >= 0; k--)
            exp_q.push_back('{b: v.msg[8*k +: 8], last: (k == 0)});
        msg = v.msg; msg_len = v.len; req_valid = 1'b1; din_ready = 1'b1;
        tick();
        t = 1;
        req_valid = 1'b0;
        check({tag, "_len_err"}, {31'd0, len_err}, {31'd0, v.exp_len_err});
        check({tag, "_start"}, {31'd0, start}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_req_ready_low"}, {31'd0, req_ready}, 32'd0);
        stall_done = 0;
        while (!finish && t < 400) begin
            if (v.stall_cycles > 0 && xfer_cnt == v.stall_after && stall_done < v.stall_cycles) begin
                din_ready = 1'b0;
                stall_done++;
            end else begin
                din_ready = 1'b1;
            end
            tick();
            t++;
            if (t == 2) check({tag, "_start_pulse"}, {31'd0, start}, 32'd0);
            if (t == 3 && v.exp_bytes > 0) begin
                check({tag, "_first_valid"}, {31'd0, din_valid}, 32'd1);
                check({tag, "_first_byte"}, {24'd0, din}, {24'd0, v.exp_first});
            end
        end
        tf_exp = v.exp_bytes + v.stall_cycles + 3;
        check({tag, "_finish_cycle"}, t, tf_exp);
        check({tag, "_finish"}, {31'd0, finish}, 32'd1);
        check({tag, "_valid_off"}, {31'd0, din_valid}, 32'd0);
        din_ready = 1'b1;
        dout_end = 1'b1;
        tick();
        check({tag, "_finish_pulse"}, {31'd0, finish}, 32'd0);
        check({tag, "_no_early_done"}, {31'd0, done}, 32'd0);
        dout_end = 1'b0;
        tick();
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, req_ready}, 32'd1);
        tick();
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_len_err_sticky"}, {31'd0, len_err}, {31'd0, v.exp_len_err});
        check({tag, "_xfers"}, xfer_cnt, v.exp_bytes);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
        check({tag, "_valid_cycles"}, valid_cycles, v.exp_bytes + v.stall_cycles);
        check({tag, "_start_cnt"}, start_cnt, 1);
        check({tag, "_finish_cnt"}, finish_cnt, 1);
        check({tag, "_done_cnt"}, done_cnt, 1);
        if (v.stall_cycles > 0) begin
            check({tag, "_hold_recorded"}, {31'd0, hold_q.size() > v.stall_after}, 32'd1);
            if (hold_q.size() > v.stall_after)
                check({tag, "_hold_len"}, hold_q[v.stall_after], v.stall_cycles + 1);
        end
    endtask

    vec_t          vecs[7];
    logic [MW-1:0] pat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; req_valid = 1'b0; msg = '0; msg_len = '0; din_ready = 1'b0; dout_end = 1'b0;
        clear_sb();

        // Byte k = k*7+3, so byte 127 (sent first) is 892 mod 256 = 0x7C.
        for (int k = 0; k < MB; k++) pat[8*k +: 8] = 8'((k * 7 + 3) % 256);

        vecs[0] = '{msg: '0,            len: 8'd0,   stall_after: 0, stall_cycles: 0, exp_len_err: 1'b0, exp_bytes: 0,   exp_first: 8'h00};
        vecs[1] = '{msg: MW'("abc"),    len: 8'd3,   stall_after: 0, stall_cycles: 0, exp_len_err: 1'b0, exp_bytes: 3,   exp_first: 8'h61};
        vecs[2] = '{msg: MW'("123"),    len: 8'd3,   stall_after: 1, stall_cycles: 4, exp_len_err: 1'b0, exp_bytes: 3,   exp_first: 8'h31};
        vecs[3] = '{msg: pat,           len: 8'd200, stall_after: 0, stall_cycles: 0, exp_len_err: 1'b1, exp_bytes: 128, exp_first: 8'h7C};
        vecs[4] = '{msg: pat,           len: 8'd128, stall_after: 0, stall_cycles: 0, exp_len_err: 1'b0, exp_bytes: 128, exp_first: 8'h7C};
        vecs[5] = '{msg: MW'("Z"),      len: 8'd1,   stall_after: 0, stall_cycles: 0, exp_len_err: 1'b0, exp_bytes: 1,   exp_first: 8'h5A};
        vecs[6] = '{msg: MW'("hello"),  len: 8'd5,   stall_after: 2, stall_cycles: 2, exp_len_err: 1'b0, exp_bytes: 5,   exp_first: 8'h68};

        tick(); tick(); tick();
        check("rst_start", {31'd0, start}, 32'd0);
        check("rst_finish", {31'd0, finish}, 32'd0);
        check("rst_din_valid", {31'd0, din_valid}, 32'd0);
        check("rst_din_end", {31'd0, din_end}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_len_err", {31'd0, len_err}, 32'd0);
        check("rst_din", {24'd0, din}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort: reset while the second of three bytes is on the bus.
        wait_req_ready("abort");
        clear_sb();
        exp_q.push_back('{b: 8'h78, last: 1'b0});
        msg = MW'("xyz"); msg_len = 8'd3; req_valid = 1'b1; din_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (xfer_cnt < 1 && n < 20) begin
            tick();
            n++;
        end
        check("abort_first_xfer", xfer_cnt, 1);
        check("abort_second_on_bus", {24'd0, din}, 32'h79);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_din_valid", {31'd0, din_valid}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_din", {24'd0, din}, 32'd0);
        check("abort_din_end", {31'd0, din_end}, 32'd0);
        check("abort_finish", {31'd0, finish}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        exp_q.delete();
        finish_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_no_finish", finish_cnt, 0);
        check("abort_no_done", done_cnt, 0);
        run_vec(vecs[1], "post_abort");

        // dout_end falling while idle must not produce done.
        done_cnt = 0;
        dout_end = 1'b1;
        tick();
        dout_end = 1'b0;
        tick();
        check("idle_fall_no_done", {31'd0, done}, 32'd0);
        tick();
        check("idle_fall_no_done2", {31'd0, done}, 32'd0);
        check("idle_fall_done_cnt", done_cnt, 0);
        run_vec(vecs[5], "post_idle_fall");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hash_msg_feeder.md
HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 128: the maximum message length in bytes.
REQ-002 SHALL have parameter LEN_W, default 8: the width of msg_len; it must be at least clog2(MAX_BYTES+1).
REQ-003 clk  in  1  single clock; all logic on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  a message request is presented.
REQ-006 req_ready  out  1  the feeder accepts a request; high only in IDLE.
REQ-007 msg  in  8*MAX_BYTES  message; byte k occupies msg[8k+:8]; byte len-1 is sent first.
REQ-008 msg_len  in  LEN_W  message length in bytes, 0..MAX_BYTES.
REQ-009 start  out  1  one-cycle pulse that opens a hash.
REQ-010 finish  out  1  one-cycle pulse that closes a hash.
REQ-011 din  out  8  message byte to the hash core.
REQ-012 din_valid  out  1  din holds a valid byte.
REQ-013 din_ready  in  1  the hash core accepts a byte.
REQ-014 din_end  out  1  marks the last byte; qualified by din_valid.
REQ-015 dout_end  in  1  the hash core's end-of-digest strobe.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse when a hash completes.
REQ-018 len_err  out  1  sticky flag: msg_len exceeded MAX_BYTES; cleared on the next accepted request.

Function
REQ-019 The FSM SHALL have the states IDLE, START, WAIT_RDY, SEND, FINISH and WAIT_END.
REQ-020 IDLE: on req_valid&&req_ready the block SHALL capture msg and msg_len (saturated to MAX_BYTES; saturation sets len_err) and go to START.
REQ-021 START: start SHALL be 1 for exactly one cycle, then the FSM goes to WAIT_RDY.
REQ-022 WAIT_RDY: the FSM SHALL stay until din_ready=1, then go to SEND if the length is nonzero, else to FINISH.
REQ-023 SEND: din_valid SHALL be 1 and din SHALL be the captured byte at index cnt-1 (cnt initialised to the length); a byte transfers on any posedge with din_valid&&din_ready.
REQ-024 On transfer, cnt SHALL decrement; din and din_end SHALL change only after a transfer; din_valid SHALL never drop while a byte is untransferred.
REQ-025 din_end SHALL be 1 exactly when cnt==1 in SEND.
REQ-026 After the last transfer, din_valid SHALL deassert on the next cycle and the FSM SHALL go to FINISH.
REQ-027 FINISH: finish SHALL be 1 for exactly one cycle, then the FSM goes to WAIT_END.
REQ-028 WAIT_END: the block SHALL detect the falling edge of dout_end (registered previous value 1, current value 0), pulse done for one cycle and return to IDLE.
REQ-029 A dout_end falling edge outside WAIT_END SHALL be ignored.
REQ-030 start, finish and din_valid SHALL be registered outputs, never combinational from inputs.
REQ-031 start and finish SHALL never be high together.
REQ-032 A new request SHALL NOT be accepted before done; back-to-back requests SHALL have at least one IDLE cycle between them.
REQ-033 Latency, request accept to the first din_valid, SHALL be 2 cycles when din_ready is held high.
REQ-034 din_ready falling mid-message SHALL stall the stream with din/din_end held and no byte lost or duplicated.

Reset
REQ-035 Synchronous rst SHALL force IDLE, with start, finish, din_valid, din_end, busy, done and len_err at 0, din at 8'h00 and cnt at 0.
REQ-036 rst asserted mid-message SHALL abort the message; outputs SHALL be at reset values on the next cycle, and no finish or done SHALL be generated.
REQ-037 After rst deasserts, req_ready SHALL be 1 on the first cycle.

Structure
REQ-038 The FSM state enum, MAX_BYTES default and LEN_W SHALL live in a shared package hash_feed_pkg, reused by the digest-side collector.
REQ-039 The design SHALL be a single module with no sub-modules; the byte selection SHALL be an indexed part-select on the captured message register.

Verification
REQ-040 msg_len=0, din_ready held 1 -> start, then finish 2 cycles later; zero din_valid cycles; done after the dout_end fall.
REQ-041 "abc" (msg_len=3), din_ready held 1 -> din 8'h61, 8'h62, 8'h63 on 3 consecutive cycles, din_end only with 8'h63, then finish.
REQ-042 "123" with din_ready low for 4 cycles after the second byte -> 8'h32 held valid for 5 cycles; sequence 31,32,33 intact.
REQ-043 msg_len=200 with MAX_BYTES=128 -> len_err=1, exactly 128 bytes sent, din_end on the 128th.
REQ-044 rst during the second of 3 bytes -> din_valid=0 and busy=0 on the next cycle; no finish; the next request hashes normally.
REQ-045 dout_end falling while IDLE, then a valid request -> no spurious done; done exactly once per request.
